// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
// Raster timing generator for one configurable video mode. Pixel-rate
// counters advance on i_en only, so the block can run from a faster system
// clock. blank/hsync/vsync/frame are registered and are decoded from the
// pre-increment counter values, so they trail the counters by one pixel.
//
// Optional build macro: VIDEO_TIMING_COORD_EN
//   Defined   -> o_x / o_y carry the active column/row of the presented pixel
//                (0 while blanked), registered alongside the other outputs.
//   Undefined -> o_x / o_y ports and their logic are absent.
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int unsigned H_RES  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33,
    parameter int unsigned H_POL  = 0,
    parameter int unsigned V_POL  = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_blank,
    output logic o_hsync,
    output logic o_vsync,
    output logic o_frame
`ifdef VIDEO_TIMING_COORD_EN
    ,
    output logic [$clog2(H_RES)-1:0] o_x,
    output logic [$clog2(V_RES)-1:0] o_y
`endif
);

    // Line / frame geometry
    localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    // Sync window boundaries (start inclusive, end exclusive)
    localparam int unsigned H_SYNC_START = H_RES + H_FP;
    localparam int unsigned H_SYNC_END   = H_RES + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_START = V_RES + V_FP;
    localparam int unsigned V_SYNC_END   = V_RES + V_FP + V_SYNC;

    // Active levels of the sync outputs
    localparam logic HS_ACT = 1'(H_POL);
    localparam logic VS_ACT = 1'(V_POL);

`ifdef VIDEO_TIMING_COORD_EN
    localparam int unsigned XW = $clog2(H_RES);
    localparam int unsigned YW = $clog2(V_RES);
`endif

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          h_last;
    logic          v_last;

    logic          h_in_active;
    logic          v_in_active;
    logic          h_in_sync;
    logic          v_in_sync;
    logic          blank_d;
    logic          hsync_d;
    logic          vsync_d;
    logic          frame_d;

`ifdef VIDEO_TIMING_COORD_EN
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d;
`endif

    // Next counter values: h wraps at end of line, v steps/wraps on that edge
    always_comb begin
        h_last = (h_cnt == HW'(H_TOTAL - 1));
        v_last = (v_cnt == VW'(V_TOTAL - 1));
        h_nxt  = h_cnt + HW'(1);
        v_nxt  = v_cnt;
        if (h_last) begin
            h_nxt = '0;
            if (v_last) begin
                v_nxt = '0;
            end else begin
                v_nxt = v_cnt + VW'(1);
            end
        end
    end

    // Decode the pixel at the current (pre-increment) counter position
    always_comb begin
        h_in_active = (h_cnt < HW'(H_RES));
        v_in_active = (v_cnt < VW'(V_RES));
        h_in_sync   = (h_cnt >= HW'(H_SYNC_START)) && (h_cnt < HW'(H_SYNC_END));
        v_in_sync   = (v_cnt >= VW'(V_SYNC_START)) && (v_cnt < VW'(V_SYNC_END));
        blank_d     = !(h_in_active && v_in_active);
        hsync_d     = h_in_sync ? HS_ACT : ~HS_ACT;
        vsync_d     = v_in_sync ? VS_ACT : ~VS_ACT;
        frame_d     = (h_cnt == '0) && (v_cnt == '0);
    end

`ifdef VIDEO_TIMING_COORD_EN
    // Coordinates of the presented pixel, forced to zero while blanked
    always_comb begin
        x_d = '0;
        y_d = '0;
        if (!blank_d) begin
            x_d = XW'(h_cnt);
            y_d = YW'(v_cnt);
        end
    end
`endif

    // Raster counters; reset restarts the frame at (0,0)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (i_en) begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Registered timing outputs, held while i_en is low
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_blank <= 1'b1;
            o_hsync <= ~HS_ACT;
            o_vsync <= ~VS_ACT;
            o_frame <= 1'b0;
        end else if (i_en) begin
            o_blank <= blank_d;
            o_hsync <= hsync_d;
            o_vsync <= vsync_d;
            o_frame <= frame_d;
        end
    end

`ifdef VIDEO_TIMING_COORD_EN
    // Registered coordinates, aligned with the timing outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_x <= '0;
            o_y <= '0;
        end else if (i_en) begin
            o_x <= x_d;
            o_y <= y_d;
        end
    end
`endif

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator directly upstream of the colour-bar/pattern stages.
- Produces registered blank, hsync and vsync for one configurable video mode.
- Pixel-rate counters advance only on a pixel-enable, so a faster system clock can drive it.
- Downstream pattern generators consume i_blank/i_hsync/i_vsync from this block unchanged.

Parameters:
- H_RES, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_RES, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low, 1 = active-high)
- V_POL, 0, vsync active level (0 = active-low, 1 = active-high)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_en  in  1  pixel enable; counters and outputs update only when high
- o_blank  out  1  high outside the active area
- o_hsync  out  1  horizontal sync, polarity per H_POL
- o_vsync  out  1  vertical sync, polarity per V_POL
- o_frame  out  1  one-pixel pulse at position (0,0)
- o_x  out  $clog2(H_RES)  active column (only with the optional feature)
- o_y  out  $clog2(V_RES)  active row (only with the optional feature)

Behaviour:
- Derived constants: H_TOTAL = H_RES+H_FP+H_SYNC+H_BP; V_TOTAL = V_RES+V_FP+V_SYNC+V_BP.
- Counter widths: h_cnt is $clog2(H_TOTAL) bits; v_cnt is $clog2(V_TOTAL) bits.
- All parameters are at least 1.
- Horizontal line order: active [0,H_RES), FP, SYNC [H_RES+H_FP, H_RES+H_FP+H_SYNC), BP.
- Vertical order uses the same layout in lines.
- Vsync changes only on line boundaries (h_cnt wraps to 0).
- Counter stepping, on an edge with i_en=1:
  - h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 after V_TOTAL-1, on the same edge that h_cnt wraps.
  - No count value outside [0,TOTAL) is ever reached.
- Outputs are registered. Each is decoded from the pre-increment counter values on the same i_en edge, so outputs lag the counters by one pixel.
- Decode rules:
  - o_blank = (h_cnt>=H_RES)|(v_cnt>=V_RES).
  - o_hsync is at the active level iff h_cnt is in SYNC.
  - o_vsync is at the active level iff v_cnt is in SYNC.
  - o_frame = (h_cnt==0)&(v_cnt==0).
- i_en=0: counters and all outputs hold their values. Enable gaps only stretch time; the sequence is unchanged.
- Reset, checked on every edge and overriding i_en:
  - h_cnt=0, v_cnt=0.
  - o_blank=1, o_hsync=~H_POL, o_vsync=~V_POL, o_frame=0, o_x=0, o_y=0.
- Reset mid-frame: the next non-reset enabled edge presents position (0,0). There is no partial-line recovery.
- Polarity: H_POL/V_POL only invert the sync outputs; blank and frame are unaffected.

Optional Feature:
- Macro: VIDEO_TIMING_COORD_EN.
- Defined:
  - o_x and o_y ports exist and are registered alongside the other outputs.
  - They carry h_cnt/v_cnt of the presented pixel when o_blank=0.
  - They are 0 when o_blank=1.
- Undefined: o_x/o_y ports and their logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use a small mode: H_RES=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_RES=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6); i_en=1 unless stated.
1. Reset and first frame:
   - Stimulus: hold i_rst 3 cycles, then release.
   - During reset: outputs blank=1, hsync=1, vsync=1, frame=0.
   - 1st enabled edge after release: frame=1, blank=0.
   - Edges 5-8: blank=1.
   - Edges 6-7: hsync=0.
2. Vertical timing:
   - Positions 24-47 (lines 3-5): blank=1 throughout.
   - Positions 32-39 (line 4): vsync=0; otherwise vsync=1.
   - o_frame pulses at positions 0, 48 and 96 only; line count wraps 5 to 0.
3. Enable gaps:
   - Stimulus: toggle i_en 1,0,0,1 repeatedly.
   - Outputs hold across i_en=0.
   - The sequence of output vectors on enabled edges equals scenario 2's sequence exactly.
4. Mid-frame reset:
   - Stimulus: assert i_rst at position 20 for 1 cycle.
   - Reset values appear on that edge.
   - The next enabled edge shows frame=1, blank=0, i.e. position (0,0).
5. Polarity:
   - Stimulus: H_POL=1, V_POL=1.
   - Reset values are hsync=0, vsync=0.
   - hsync=1 at positions 5-6 of each line; vsync=1 on line 4.
   - Blank timing is unchanged.
6. VIDEO_TIMING_COORD_EN defined:
   - o_x/o_y = (0,0),(1,0),(2,0),(3,0) at positions 0-3.
   - 0/0 while blank.
   - (3,2) at position 19.
